tdc_encoder_pipe: RTL and testbench

Parametrised, pipelined, multi-channel successor to the combinational TDC encoder. Each channel takes a thermometer-style fine code from the delay line and two phase-shifted coarse ripple counters (A/B), and produces a binary timestamp. A round-robin arbiter merges the per-channel results into one valid/ready output stream tagged with channel ID. Sits between the TDC front-end capture registers and the readout FIFO, in the clk40M domain.

---
 rtl/tdc_encoder_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_tdc_encoder_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_encoder_pipe.sv
// Pipelined multi-channel TDC encoder: fine-code bubble correction, thermometer-to-binary
// conversion, coarse A/B select, per-channel hold and round-robin merge. Macro: TDC_BUBBLE_CORR_EN.
module tdc_encoder_pipe #(
    parameter int NUM_CH    = 4,
    parameter int FINE_BITS = 55,
    parameter int CNT_BITS  = 5,
    parameter int OUT_BITS  = 12,
    parameter int CH_W      = 2
) (
    input  logic                          clk40M,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             hit_valid,
    input  logic [NUM_CH*FINE_BITS-1:0]   fine_raw_code,
    input  logic [NUM_CH*CNT_BITS-1:0]    counterA,
    input  logic [NUM_CH*CNT_BITS-1:0]    counterB,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITS-1:0]           out_code,
    output logic [CH_W-1:0]               out_ch,
    output logic                          out_err,
    output logic [NUM_CH-1:0]             ovf_flag,
    input  logic                          clear_ovf
);

    localparam int FP_W = (FINE_BITS > 1) ? $clog2(FINE_BITS) : 1;

    generate
        if ((64'd1 << OUT_BITS) < ((64'd1 << CNT_BITS) * 64'(FINE_BITS))) begin : g_bad_out_bits
            $error("tdc_encoder_pipe: OUT_BITS too small for CNT_BITS and FINE_BITS");
        end
        if ((64'd1 << CH_W) < 64'(NUM_CH)) begin : g_bad_ch_w
            $error("tdc_encoder_pipe: CH_W too small for NUM_CH");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("tdc_encoder_pipe: NUM_CH must be 1..16");
        end
    endgenerate

    // Majority-of-three across neighbours removes single-bit bubbles; edges padded 1 below, 0 above.
    function automatic logic [FINE_BITS-1:0] correct_code(input logic [FINE_BITS-1:0] b);
        logic [FINE_BITS-1:0] c;
`ifdef TDC_BUBBLE_CORR_EN
        logic [FINE_BITS+1:0] ext;
        ext = {1'b0, b, 1'b1};
        for (int i = 0; i < FINE_BITS; i++) begin
            c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
`else
        c = b;
`endif
        return c;
    endfunction

    // Returns {err, fine_pos}: run length of ones from bit 0 (clipped), err if any 1 sits above a 0.
    function automatic logic [FP_W:0] thermo_decode(input logic [FINE_BITS-1:0] c);
        int   cnt;
        logic seen_zero;
        logic err;
        cnt       = 0;
        seen_zero = 1'b0;
        err       = 1'b0;
        for (int i = 0; i < FINE_BITS; i++) begin
            if (!c[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                err = 1'b1;
            end else begin
                cnt = cnt + 1;
            end
        end
        if (cnt >= FINE_BITS) begin
            cnt = FINE_BITS - 1;
        end
        return {err, FP_W'(cnt)};
    endfunction

    function automatic int rr_index(input logic [CH_W-1:0] p, input int i);
        int v;
        v = int'(p) + i;
        if (v >= NUM_CH) begin
            v = v - NUM_CH;
        end
        return v;
    endfunction

    logic [NUM_CH-1:0]    s1_valid;
    logic [FINE_BITS-1:0] s1_code   [NUM_CH];
    logic [CNT_BITS-1:0]  s1_a      [NUM_CH];
    logic [CNT_BITS-1:0]  s1_b      [NUM_CH];

    logic [NUM_CH-1:0]    s2_valid;
    logic [FP_W-1:0]      s2_fpos   [NUM_CH];
    logic                 s2_err    [NUM_CH];
    logic [CNT_BITS-1:0]  s2_coarse [NUM_CH];

    logic [NUM_CH-1:0]    hold_valid;
    logic [OUT_BITS-1:0]  hold_code [NUM_CH];
    logic                 hold_err  [NUM_CH];

    logic [FP_W:0]        dec_c     [NUM_CH];
    logic [CNT_BITS-1:0]  coarse_c  [NUM_CH];
    logic [OUT_BITS-1:0]  code_c    [NUM_CH];

    logic [CH_W-1:0]      rr_ptr;
    logic                 gnt_found;
    logic [CH_W-1:0]      gnt_idx;
    logic [NUM_CH-1:0]    grant;
    logic                 can_load;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            dec_c[k] = thermo_decode(s1_code[k]);
            if (int'(dec_c[k][FP_W-1:0]) < FINE_BITS / 2) begin
                coarse_c[k] = s1_a[k];
            end else begin
                coarse_c[k] = s1_b[k];
            end
            code_c[k] = OUT_BITS'(s2_coarse[k]) * OUT_BITS'(FINE_BITS) + OUT_BITS'(s2_fpos[k]);
        end
    end

    // Output handshake: a word moves when out_valid && out_ready on the clock edge; while
    // out_valid is high and out_ready low the word is frozen. The output register may reload
    // in the same cycle it is drained.
    assign can_load = !out_valid || out_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && hold_valid[rr_index(rr_ptr, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(rr_index(rr_ptr, i));
            end
        end
        grant = '0;
        if (can_load && gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            s1_valid   <= '0;
            s2_valid   <= '0;
            hold_valid <= '0;
            ovf_flag   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                s1_code[k]   <= '0;
                s1_a[k]      <= '0;
                s1_b[k]      <= '0;
                s2_fpos[k]   <= '0;
                s2_err[k]    <= 1'b0;
                s2_coarse[k] <= '0;
                hold_code[k] <= '0;
                hold_err[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                s1_valid[k] <= hit_valid[k];
                if (hit_valid[k]) begin
                    s1_code[k] <= correct_code(fine_raw_code[k*FINE_BITS +: FINE_BITS]);
                    s1_a[k]    <= counterA[k*CNT_BITS +: CNT_BITS];
                    s1_b[k]    <= counterB[k*CNT_BITS +: CNT_BITS];
                end

                s2_valid[k] <= s1_valid[k];
                if (s1_valid[k]) begin
                    s2_fpos[k]   <= dec_c[k][FP_W-1:0];
                    s2_err[k]    <= dec_c[k][FP_W];
                    s2_coarse[k] <= coarse_c[k];
                end

                // A full hold register accepts a new result only when it is drained this cycle.
                if (s2_valid[k] && (!hold_valid[k] || grant[k])) begin
                    hold_valid[k] <= 1'b1;
                    hold_code[k]  <= code_c[k];
                    hold_err[k]   <= s2_err[k];
                end else if (grant[k]) begin
                    hold_valid[k] <= 1'b0;
                end

                if (s2_valid[k] && hold_valid[k] && !grant[k]) begin
                    ovf_flag[k] <= 1'b1;
                end else if (clear_ovf) begin
                    ovf_flag[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_ch    <= '0;
            out_err   <= 1'b0;
            rr_ptr    <= '0;
        end else if (can_load) begin
            out_valid <= gnt_found;
            if (gnt_found) begin
                out_code <= hold_code[gnt_idx];
                out_ch   <= gnt_idx;
                out_err  <= hold_err[gnt_idx];
                rr_ptr   <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_encoder_pipe.sv
// Scoreboard bench for tdc_encoder_pipe: directed hits push expected words, a negedge
// monitor pops and compares every transferred word.
module tb_tdc_encoder_pipe;

    localparam int NUM_CH    = 4;
    localparam int FINE_BITS = 55;
    localparam int CNT_BITS  = 5;
    localparam int OUT_BITS  = 12;
    localparam int CH_W      = 2;
    localparam int W         = 1 + CH_W + OUT_BITS;

    logic                        clk40M;
    logic                        reset;
    logic [NUM_CH-1:0]           hit_valid;
    logic [NUM_CH*FINE_BITS-1:0] fine_raw_code;
    logic [NUM_CH*CNT_BITS-1:0]  counterA;
    logic [NUM_CH*CNT_BITS-1:0]  counterB;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_BITS-1:0]         out_code;
    logic [CH_W-1:0]             out_ch;
    logic                        out_err;
    logic [NUM_CH-1:0]           ovf_flag;
    logic                        clear_ovf;

    tdc_encoder_pipe #(
        .NUM_CH(NUM_CH), .FINE_BITS(FINE_BITS), .CNT_BITS(CNT_BITS),
        .OUT_BITS(OUT_BITS), .CH_W(CH_W)
    ) dut (
        .clk40M(clk40M), .reset(reset), .hit_valid(hit_valid),
        .fine_raw_code(fine_raw_code), .counterA(counterA), .counterB(counterB),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_ch(out_ch), .out_err(out_err), .ovf_flag(ovf_flag), .clear_ovf(clear_ovf)
    );

    // clock / reset
    initial clk40M = 1'b0;
    always #5 clk40M = ~clk40M;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [FINE_BITS-1:0] ones(input int n);
        logic [FINE_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    // driver tasks
    task automatic set_ch(input int ch, input logic [FINE_BITS-1:0] fine, input int a, input int b);
        hit_valid[ch] = 1'b1;
        fine_raw_code[ch*FINE_BITS +: FINE_BITS] = fine;
        counterA[ch*CNT_BITS +: CNT_BITS] = CNT_BITS'(a);
        counterB[ch*CNT_BITS +: CNT_BITS] = CNT_BITS'(b);
    endtask

    task automatic pulse();
        @(posedge clk40M);
        #1;
        hit_valid = '0;
    endtask

    task automatic push_exp(input int ch, input int code, input logic err);
        exp_q.push_back({err, CH_W'(ch), OUT_BITS'(code)});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid) return;
            @(posedge clk40M);
            #1;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: drain timeout, pending=%0d expected=0", name, exp_q.size());
    endtask

    // monitor / scoreboard
    logic [W-1:0] mon_word;
    logic [W-1:0] stall_word;
    logic [W-1:0] exp_word;
    logic         stall;
    assign mon_word = {out_err, out_ch, out_code};

    always @(negedge clk40M) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) chk("hold_stable", {out_valid, mon_word}, {1'b1, stall_word});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got ch=%0d code=%0d err=%0d expected=none",
                             out_ch, out_code, out_err);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("out_word", mon_word, exp_word);
                end
            end
            stall      = out_valid && !out_ready;
            stall_word = mon_word;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    logic [FINE_BITS-1:0] f;

    initial begin
        reset = 1'b1;
        hit_valid = '0;
        fine_raw_code = '0;
        counterA = '0;
        counterB = '0;
        out_ready = 1'b1;
        clear_ovf = 1'b0;
        repeat (3) @(posedge clk40M);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_ovf", ovf_flag, 0);
        reset = 1'b0;
        @(posedge clk40M);
        #1;

        // ch0: 10 ones, A selected, 3-cycle latency
        set_ch(0, ones(10), 3, 9);
        push_exp(0, 175, 1'b0);
        pulse();
        repeat (2) begin
            @(posedge clk40M);
            #1;
            chk("lat_early", out_valid, 0);
        end
        @(posedge clk40M);
        #1;
        chk("lat_n3", out_valid, 1);
        wait_drain("t1");

        // ch2: 40 ones, B selected
        set_ch(2, ones(40), 1, 7);
        push_exp(2, 425, 1'b0);
        pulse();
        wait_drain("t2");

        // ch1: bubble at bit 5
        f = ones(20);
        f[5] = 1'b0;
        set_ch(1, f, 4, 8);
`ifdef TDC_BUBBLE_CORR_EN
        push_exp(1, 240, 1'b0);
`else
        push_exp(1, 225, 1'b1);
`endif
        pulse();
        wait_drain("t3");

        // all-zero on ch0, all-ones on ch3; pointer sits at ch2 so ch3 goes first
        set_ch(0, '0, 4, 12);
        set_ch(3, '1, 2, 31);
        push_exp(3, 1759, 1'b0);
        push_exp(0, 220, 1'b0);
        pulse();
        wait_drain("t_edges");

        // overflow: three back-to-back hits on ch3 with the output stalled
        out_ready = 1'b0;
        set_ch(3, ones(5), 2, 0);
        push_exp(3, 115, 1'b0);
        pulse();
        set_ch(3, ones(30), 0, 6);
        push_exp(3, 360, 1'b0);
        pulse();
        set_ch(3, ones(1), 9, 0);
        pulse();
        repeat (8) @(posedge clk40M);
        #1;
        chk("ovf_set", ovf_flag, 4'b1000);
        chk("ovf_outreg_full", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("t_ovf");
        chk("ovf_sticky", ovf_flag, 4'b1000);
        clear_ovf = 1'b1;
        @(posedge clk40M);
        #1;
        clear_ovf = 1'b0;
        chk("ovf_cleared", ovf_flag, 0);

        // reset one cycle after a hit discards it
        set_ch(1, ones(7), 5, 5);
        pulse();
        @(posedge clk40M);
        #1;
        reset = 1'b1;
        @(posedge clk40M);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk40M);
        #1;
        chk("reset_discard", out_valid, 0);
        chk("reset_ovf", ovf_flag, 0);

        set_ch(3, ones(12), 7, 0);
        push_exp(3, 397, 1'b0);
        pulse();
        wait_drain("t_post_reset");

        // four simultaneous hits, twice; pointer sits at ch0 both times
        set_ch(0, ones(1), 1, 0);
        set_ch(1, ones(2), 2, 0);
        set_ch(2, ones(50), 0, 3);
        set_ch(3, ones(27), 0, 4);
        push_exp(0, 56, 1'b0);
        push_exp(1, 112, 1'b0);
        push_exp(2, 215, 1'b0);
        push_exp(3, 247, 1'b0);
        pulse();
        wait_drain("t_all4_a");

        set_ch(0, ones(26), 10, 0);
        set_ch(1, ones(54), 0, 2);
        set_ch(2, ones(3), 20, 0);
        set_ch(3, ones(45), 0, 15);
        push_exp(0, 576, 1'b0);
        push_exp(1, 164, 1'b0);
        push_exp(2, 1103, 1'b0);
        push_exp(3, 870, 1'b0);
        pulse();
        wait_drain("t_all4_b");

        repeat (5) @(posedge clk40M);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
